// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment driver. Display inputs are
// shadowed at each frame boundary; adds leading-zero blanking, PWM dimming and blink.

module sevenseg_digit_lane #(
  parameter bit MAY_SUPPRESS = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       dp,
  input  logic       blink,
  input  logic       blink_phase,
  input  logic       blz,
  input  logic       zero_above,
  output logic       zero_here,
  output logic       qual
);
  // zero_here: this nibble and every nibble to its left are 0 with no dp lit
  assign zero_here = zero_above & (nib == 4'h0) & ~dp;
  assign qual      = en & ~(blz & zero_here & MAY_SUPPRESS) & ~(blink & blink_phase);
endmodule

module sevenseg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int DIGIT_PERIOD = 131072,
  parameter int BRIGHT_BITS  = 3,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [4*DIGITS-1:0]    value,
  input  logic [DIGITS-1:0]      digit_enable,
  input  logic [DIGITS-1:0]      dp,
  input  logic                   blank_leading_zeros,
  input  logic [BRIGHT_BITS-1:0] brightness,
  input  logic [DIGITS-1:0]      blink_mask,
  output logic [6:0]             segments_n,
  output logic                   dp_n,
  output logic [DIGITS-1:0]      digit_enable_n,
  output logic                   frame_start
);
  localparam int SLOT_W  = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SUB_LEN = DIGIT_PERIOD >> BRIGHT_BITS;
  localparam int SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_PERIOD - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(SUB_LEN - 1);

  typedef struct packed {
    logic [DIGITS-1:0][3:0]   nib;
    logic [DIGITS-1:0]        en;
    logic [DIGITS-1:0]        dp;
    logic                     blz;
    logic [BRIGHT_BITS-1:0]   bright;
    logic [DIGITS-1:0]        blink;
    logic                     phase;
  } shadow_t;

  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SUB_W-1:0]       sub_cnt_q, sub_cnt_d;
  logic [BRIGHT_BITS-1:0] sub_idx_q, sub_idx_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic                   phase_q, phase_d;
  shadow_t                shadow_q, shadow_d, live, eff;

  logic [6:0]        segments_n_q, segments_n_d;
  logic              dp_n_q, dp_n_d;
  logic [DIGITS-1:0] digit_enable_n_q, digit_enable_n_d;
  logic              frame_start_q, frame_start_d;

  logic              boundary, slot_wrap, pwm_on, lit;
  logic [DIGITS:0]   zero_run;
  logic [DIGITS-1:0] qual;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h7E;
      4'h1: hex_font = 7'h30;
      4'h2: hex_font = 7'h6D;
      4'h3: hex_font = 7'h79;
      4'h4: hex_font = 7'h33;
      4'h5: hex_font = 7'h5B;
      4'h6: hex_font = 7'h5F;
      4'h7: hex_font = 7'h70;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h7B;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h1F;
      4'hC: hex_font = 7'h0D;
      4'hD: hex_font = 7'h3D;
      4'hE: hex_font = 7'h4F;
      default: hex_font = 7'h47;
    endcase
  endfunction

  assign boundary  = (slot_q == '0) && (idx_q == IDX_LAST);
  assign slot_wrap = (slot_q == SLOT_LAST);

  always_comb begin
    live.nib    = value;
    live.en     = digit_enable;
    live.dp     = dp;
    live.blz    = blank_leading_zeros;
    live.bright = brightness;
    live.blink  = blink_mask;
    live.phase  = phase_q;
  end

  // The frame's first slot must already see the freshly captured settings.
  assign eff      = boundary ? live : shadow_q;
  assign shadow_d = eff;

  assign zero_run[DIGITS] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    sevenseg_digit_lane #(.MAY_SUPPRESS(i > 0)) u_lane (
      .nib         (eff.nib[i]),
      .en          (eff.en[i]),
      .dp          (eff.dp[i]),
      .blink       (eff.blink[i]),
      .blink_phase (eff.phase),
      .blz         (eff.blz),
      .zero_above  (zero_run[i+1]),
      .zero_here   (zero_run[i]),
      .qual        (qual[i])
    );
  end

  always_comb begin
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d     = idx_q;
    sub_cnt_d = sub_cnt_q + 1'b1;
    sub_idx_d = sub_idx_q;
    frame_d   = frame_q;
    phase_d   = phase_q;
    if (slot_wrap) idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
    if (sub_cnt_q == SUB_LAST) begin
      sub_cnt_d = '0;
      sub_idx_d = sub_idx_q + 1'b1;
    end
    if (boundary) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Top sub-period is never reached by brightness, leaving dead time per slot.
  assign pwm_on = (sub_idx_q < eff.bright);
  assign lit    = qual[idx_q] & pwm_on;

  always_comb begin
    segments_n_d     = 7'h7F;
    dp_n_d           = 1'b1;
    digit_enable_n_d = '1;
    frame_start_d    = boundary;
    if (lit) begin
      segments_n_d     = ~hex_font(eff.nib[idx_q]);
      dp_n_d           = ~eff.dp[idx_q];
      digit_enable_n_d = ~(DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_q           <= '0;
      idx_q            <= IDX_LAST;
      sub_cnt_q        <= '0;
      sub_idx_q        <= '0;
      frame_q          <= '0;
      phase_q          <= 1'b0;
      shadow_q         <= '0;
      segments_n_q     <= 7'h7F;
      dp_n_q           <= 1'b1;
      digit_enable_n_q <= '1;
      frame_start_q    <= 1'b0;
    end else begin
      slot_q           <= slot_d;
      idx_q            <= idx_d;
      sub_cnt_q        <= sub_cnt_d;
      sub_idx_q        <= sub_idx_d;
      frame_q          <= frame_d;
      phase_q          <= phase_d;
      shadow_q         <= shadow_d;
      segments_n_q     <= segments_n_d;
      dp_n_q           <= dp_n_d;
      digit_enable_n_q <= digit_enable_n_d;
      frame_start_q    <= frame_start_d;
    end
  end

  assign segments_n     = segments_n_q;
  assign dp_n           = dp_n_q;
  assign digit_enable_n = digit_enable_n_q;
  assign frame_start    = frame_start_q;
endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Parametrised multiplexed seven-segment driver and successor to the fixed 4-digit scanner. It drives N common-anode digits from a packed hex value and adds decimal points, leading-zero suppression, PWM brightness, per-digit blink and frame-synchronous input capture. It sits between datapath/frontend logic and the board display pins, clocked from the master clock.

Parameters:
DIGITS, 4, number of digits scanned; digit DIGITS-1 is leftmost and shows value[4*DIGITS-1 -: 4].
DIGIT_PERIOD, 131072, clock cycles per digit slot; must be a multiple of 2**BRIGHT_BITS and at least 2**BRIGHT_BITS.
BRIGHT_BITS, 3, width of the brightness control.
BLINK_FRAMES, 32, frames per blink half-period; must be at least 1.

Ports:
clock  in  1  master clock
reset_n  in  1  synchronous reset, active low
value  in  4*DIGITS  packed hex nibbles; digit i = value[4*i+3:4*i]
digit_enable  in  DIGITS  1 = digit i may light
dp  in  DIGITS  1 = decimal point of digit i lit
blank_leading_zeros  in  1  enable leading-zero suppression
brightness  in  BRIGHT_BITS  duty level; 0 = dark, max = (2**B-1)/2**B
blink_mask  in  DIGITS  1 = digit i blinks
segments_n  out  7  active-low segments; bit6 = a ... bit0 = g
dp_n  out  1  active-low decimal point
digit_enable_n  out  DIGITS  active-low digit select; bit i = digit i
frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (reset_n = 0 at a clock edge): segments_n = 7'h7F, dp_n = 1, digit_enable_n = all 1, frame_start = 0. Slot counter = 0, digit index = DIGITS-1, frame count = 0, blink phase = 0, shadow registers = 0. Reset mid-frame aborts the scan immediately with no partial slot.
- Slot counter counts 0..DIGIT_PERIOD-1 and wraps.
- On wrap, the digit index decrements; from digit 0 it wraps to DIGITS-1, which ends the frame.
- Frame boundary is slot counter = 0 with index = DIGITS-1, including the first cycle after reset release.
- At a frame boundary, value, digit_enable, dp, blank_leading_zeros, brightness and blink_mask load into shadow registers. All display logic uses shadows only, so input changes take effect at the next frame and never tear mid-frame.
- All outputs are registered, one cycle after internal state. frame_start = 1 in the first output cycle of digit DIGITS-1's slot.
- Frame length is DIGITS*DIGIT_PERIOD cycles.
- Hex font (a..g as bit6..0): 0 7E, 1 30, 2 6D, 3 79, 4 33, 5 5B, 6 5F, 7 70, 8 7F, 9 7B, A 77, B 1F, C 0D, D 3D, E 4F, F 47.
- Leading-zero suppression: digit i (i > 0) is suppressed when blank_leading_zeros = 1, all nibbles i..DIGITS-1 are 0, and dp is 0 for digits i..DIGITS-1. Digit 0 is never suppressed. Disabled digits still count in the zero run.
- PWM: the slot is split into 2**BRIGHT_BITS equal sub-periods; sub-index = slot_counter / (DIGIT_PERIOD >> BRIGHT_BITS). The digit is lit only while sub-index < brightness. Sub-index 2**B-1 is never lit, which gives dead-time between digits.
- Blink: the frame count increments at each frame boundary. At BLINK_FRAMES-1 it wraps to 0 and toggles blink phase. While blink phase = 1, digits with blink_mask set are dark.
- Digit lit = digit_enable & ~suppressed & ~(blink_mask & blink_phase) & PWM-on.
- When the current digit is lit: digit_enable_n bit = 0, others 1; segments_n = ~font; dp_n = ~dp.
- When the current digit is dark: all digit_enable_n = 1, segments_n = 7'h7F, dp_n = 1.
- At most one digit_enable_n bit is 0 in any cycle.
- Whenever all digit_enable_n bits are 1, segments_n = 7'h7F and dp_n = 1.

Test Plan:
All scenarios use DIGITS=4, DIGIT_PERIOD=16, BRIGHT_BITS=2, BLINK_FRAMES=2.
1. Reset release with value=16'h12AF, enables 4'hF, brightness=3, no blink. Expect frame_start 1 cycle after release; digit_enable_n=4'b0111 with segments_n=~7'h30 for 12 cycles, then dark 4 cycles; then digits 2, 1, 0 show 6D, 77, 47. Frame length is 64 cycles.
2. value=16'h0050, blank_leading_zeros=1. Digits 3 and 2 stay dark and digits 1 and 0 show 5B and 7E. Repeat with dp[2]=1: digit 2 shows 7E with dp_n=0.
3. value=16'h0000 with blanking on. Only digit 0 lights, showing 7E.
4. brightness=1 lights each digit for 4 of 16 cycles. brightness=0 keeps digit_enable_n=4'hF for the whole frame.
5. blink_mask=4'b0001. Digit 0 lights in frames 0-1, is dark in frames 2-3, lights again in frames 4-5; other digits are unaffected.
6. Change value mid-frame. Output is unchanged until the next frame_start. Assert reset_n=0 mid-slot: outputs reach reset values at the next edge, and the scan restarts at digit 3.
